serial_rca: RTL and testbench
=============================

SERIAL_RCA -- requirements
Module: serial_rca

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits; SHALL be legal for any value >= 1.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A, unsigned magnitude or two's complement.
REQ-006 Port: b  input  WIDTH  operand B, same encoding as a.
REQ-007 Port: ci  input  1  carry-in.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse marking a new result.
REQ-010 Port: s  output  WIDTH  registered sum.
REQ-011 Port: co  output  1  registered carry-out.
REQ-012 Port: ovf  output  1  signed overflow; present only per REQ-027.

Function
REQ-013 The block SHALL compute {co,s} = a + b + ci bit-serially, LSB first, one bit per clock, through a full adder built from two half adders.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at edge k: a, b and ci are latched into internal shift/carry registers, the bit counter is cleared, and the state becomes RUN.
REQ-016 In RUN, each edge SHALL process bit[cnt], store the sum bit, update the internal carry and increment cnt; when cnt=WIDTH-1 the state SHALL become DONE, i.e. at edge k+WIDTH.
REQ-017 At the RUN->DONE edge, s and co SHALL load the full new result; at all other times they SHALL hold their last value, including while the block is running.
REQ-018 busy SHALL be 1 exactly when state=RUN; done SHALL be 1 exactly when state=DONE, lasting one cycle.
REQ-019 Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH; throughput is one result per WIDTH+1 cycles.
REQ-020 start in RUN SHALL be ignored and SHALL NOT disturb the latched operands.
REQ-021 start=1 in DONE SHALL latch new operands and go directly to RUN (back-to-back); otherwise DONE->IDLE.
REQ-022 Changes on a, b or ci after the latch edge SHALL NOT affect the result in progress.
REQ-023 WIDTH=1 SHALL take exactly one RUN cycle.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, cnt=0, internal carry=0, s=0, co=0, busy=0, done=0 and ovf=0, independent of clk.
REQ-025 Reset asserted during RUN SHALL abort the operation without producing a done pulse, and SHALL leave no partial result on s.
REQ-026 After reset_n rises, the first start SHALL be accepted on the first rising edge with start=1.

Configuration
REQ-027 Macro SERIAL_RCA_OVF_EN: when defined, port ovf SHALL exist and SHALL be loaded with the XOR of the carry into the MSB and the carry out of the MSB at the RUN->DONE edge, then held with s. When the macro is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8 unless stated)
REQ-028 reset_n low mid-stream -> s=0, co=0, busy=0, done=0 and ovf=0 asynchronously, before the next clk edge.
REQ-029 a=0x3C, b=0x15, ci=0, start pulse -> busy high for 8 cycles, then done for 1 cycle, with s=0x51 and co=0.
REQ-030 a=0xFF, b=0x00, ci=1 -> s=0x00, co=1; with SERIAL_RCA_OVF_EN, a=0x7F, b=0x01, ci=0 -> s=0x80, ovf=1.
REQ-031 start held high across DONE with new operands a=0x01, b=0x02 -> no idle cycle between operations; the second done gives s=0x03; start pulses during RUN are ignored.
REQ-032 reset_n pulsed low at the 4th RUN cycle -> no done pulse, and the next addition after reset is correct.
REQ-033 WIDTH=1, a=1, b=1, ci=1 -> done 2 cycles after start, with s=1 and co=1.

Source files
------------

// File: rtl/serial_rca.sv
// -----------------------------------------------------------------------------
// serial_rca
//   Bit-serial ripple-carry adder. Computes {co,s} = a + b + ci one bit per
//   clock, LSB first, through a full adder built from two half adders. The
//   operands are captured on the start edge. s/co (and ovf) update only when
//   the last bit has been processed and otherwise hold their last value.
//
//   Parameters
//     WIDTH    operand / sum width in bits (>= 1)
//
//   Ports
//     clk      sole clock, rising edge
//     reset_n  asynchronous active-low reset
//     start    begin an addition (accepted in IDLE and DONE)
//     a, b     operands (unsigned or two's complement)
//     ci       carry-in
//     busy     high while bits are being processed (state RUN)
//     done     one-cycle pulse marking a new result (state DONE)
//     s        registered sum
//     co       registered carry-out
//     ovf      registered signed overflow (only with SERIAL_RCA_OVF_EN)
//
//   Build option
//     SERIAL_RCA_OVF_EN  when defined, adds port ovf and its logic.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | processing bit[cnt]; leaves after the MSB
//   DONE  | result valid pulse; start here chains straight into RUN
// -----------------------------------------------------------------------------
module serial_rca #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
`ifdef SERIAL_RCA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
`ifdef SERIAL_RCA_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Full adder from two half adders on the current LSBs.
   logic ha1_s, ha1_c, ha2_c, fa_sum, fa_cout;
   assign ha1_s   = a_sh_q[0] ^ b_sh_q[0];
   assign ha1_c   = a_sh_q[0] & b_sh_q[0];
   assign fa_sum  = ha1_s ^ carry_q;
   assign ha2_c   = ha1_s & carry_q;
   assign fa_cout = ha1_c | ha2_c;

   // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
   logic [WIDTH:0]   sum_cat;
   logic [WIDTH-1:0] sum_next;
   assign sum_cat  = {fa_sum, sum_sh_q};
   assign sum_next = sum_cat[WIDTH:1];

   logic load;
   assign load = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      s_d      = s_q;
      co_d     = co_q;
`ifdef SERIAL_RCA_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         IDLE: ;
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_next;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               s_d     = sum_next;
               co_d    = fa_cout;
`ifdef SERIAL_RCA_OVF_EN
               // carry_q is the carry into the MSB at this point.
               ovf_d   = carry_q ^ fa_cout;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Start is only honoured outside RUN so running operands stay intact.
      if (load) begin
         state_d = RUN;
         cnt_d   = '0;
         a_sh_d  = a;
         b_sh_d  = b;
         carry_d = ci;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         s_q      <= '0;
         co_q     <= 1'b0;
`ifdef SERIAL_RCA_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         s_q      <= s_d;
         co_q     <= co_d;
`ifdef SERIAL_RCA_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
`ifdef SERIAL_RCA_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_rca.sv
// -----------------------------------------------------------------------------
// tb_serial_rca
//   Bench for serial_rca: a WIDTH=8 instance with directed and random additions
//   compared against plain integer arithmetic, plus a WIDTH=1 instance.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_serial_rca;

   localparam int W = 8;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         ci;
   logic         busy, done;
   logic [W-1:0] s;
   logic         co;
`ifdef SERIAL_RCA_OVF_EN
   logic         ovf;
`endif

   logic start1, a1, b1, ci1;
   logic busy1, done1, s1, co1;
`ifdef SERIAL_RCA_OVF_EN
   logic ovf1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Last completed result, expected to be held while a new one is computed.
   logic [W-1:0] held_s   = '0;
   logic         held_co  = 1'b0;
   logic         held_ovf = 1'b0;

   serial_rca #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ci      (ci),
      .busy    (busy),
      .done    (done),
      .s       (s),
      .co      (co)
`ifdef SERIAL_RCA_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   serial_rca #(.WIDTH(1)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start1),
      .a       (a1),
      .b       (b1),
      .ci      (ci1),
      .busy    (busy1),
      .done    (done1),
      .s       (s1),
      .co      (co1)
`ifdef SERIAL_RCA_OVF_EN
      ,
      .ovf     (ovf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an addition, optionally scribbling on the inputs while it runs,
   // and check the held outputs during RUN and the result in DONE.
   // Leaves the DUT in DONE with start low.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input bit scribble, input string tag);
      int          total;
      logic [W:0]  tot;
      logic        exp_ovf;
      total   = int'(av) + int'(bv) + int'(cv);
      tot     = total[W:0];
      exp_ovf = (av[W-1] == bv[W-1]) && (tot[W-1] != av[W-1]);
      start = 1'b1; a = av; b = bv; ci = cv;
      tick();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         check({tag, "_s_hold"}, 32'(s), 32'(held_s));
         if (scribble) begin
            a     = W'($urandom);
            b     = W'($urandom);
            ci    = 1'($urandom);
            start = (i < W - 1) ? 1'($urandom) : 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_s"}, 32'(s), 32'(tot[W-1:0]));
      check({tag, "_co"}, 32'(co), 32'(tot[W]));
`ifdef SERIAL_RCA_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
      held_s   = tot[W-1:0];
      held_co  = tot[W];
      held_ovf = exp_ovf;
   endtask

   task automatic idle_after(input string tag);
      start = 1'b0;
      tick();
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_s"}, 32'(s), 32'(held_s));
      check({tag, "_idle_co"}, 32'(co), 32'(held_co));
   endtask

   initial begin
      logic saw_done;
      reset_n = 1'b0;
      start = 1'b0; a = '0; b = '0; ci = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      #2;
      check("rst_s", 32'(s), 32'd0);
      check("rst_co", 32'(co), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_RCA_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Directed cases
      run_op(8'h3C, 8'h15, 1'b0, 1'b1, "d3c15");
      idle_after("d3c15");
      run_op(8'hFF, 8'h00, 1'b1, 1'b0, "dff00");
      idle_after("dff00");
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, "d7f01");
      idle_after("d7f01");

      // Back-to-back: the second start is sampled in DONE, so the first
      // observation after it must already be busy.
      run_op(8'h10, 8'h20, 1'b1, 1'b1, "b2b_a");
      run_op(8'h01, 8'h02, 1'b0, 1'b1, "b2b_b");
      idle_after("b2b_b");

      // Reset asserted during the 4th RUN cycle
      start = 1'b1; a = 8'hA5; b = 8'h5A; ci = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("mid_busy", 32'(busy), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_s", 32'(s), 32'd0);
      check("mid_rst_co", 32'(co), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
`ifdef SERIAL_RCA_OVF_EN
      check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
      held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      check("mid_no_done", 32'(saw_done), 32'd0);
      check("mid_s_clear", 32'(s), 32'd0);
      run_op(8'hC3, 8'h4E, 1'b1, 1'b1, "post_rst");
      idle_after("post_rst");

      // Random additions, randomly chained back-to-back
      for (int n = 0; n < 20; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "rnd");
         if ($urandom_range(0, 1) == 0) idle_after("rnd");
      end
      idle_after("rnd_end");

      // WIDTH=1 instance
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      check("w1_nodone", 32'(done1), 32'd0);
      tick();
      check("w1_done", 32'(done1), 32'd1);
      check("w1_s", 32'(s1), 32'd1);
      check("w1_co", 32'(co1), 32'd1);
      tick();
      check("w1_idle", 32'(done1), 32'd0);
      for (int n = 0; n < 6; n++) begin
         logic av, bv, cv;
         int   t;
         av = 1'($urandom); bv = 1'($urandom); cv = 1'($urandom);
         t  = int'(av) + int'(bv) + int'(cv);
         start1 = 1'b1; a1 = av; b1 = bv; ci1 = cv;
         tick();
         start1 = 1'b0;
         check("w1r_busy", 32'(busy1), 32'd1);
         tick();
         check("w1r_done", 32'(done1), 32'd1);
         check("w1r_s", 32'(s1), 32'(t % 2));
         check("w1r_co", 32'(co1), 32'(t / 2));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
